// File: rtl/imm_sequencer.sv
// imm_sequencer
//   Decode-stage immediate controller. Accepts 16-bit immediates over a
//   valid/ready handshake and produces WIDTH-bit operands: single-shot
//   sign/zero extension, or a HIGH immediate followed by a LOW immediate
//   that is paired into a 32-bit constant (sign-extended from bit 31).
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous reset, active low
//   flush_i      synchronous discard of all pending/held state
//   in_valid_i   immediate valid
//   in_ready_o   sequencer can accept an immediate this cycle
//   in_imm_i     raw 16-bit immediate
//   in_mode_i    00 SEXT, 01 ZEXT, 10 HIGH, 11 reserved
//   out_valid_o  out_data_o/out_err_o valid
//   out_ready_i  consumer accepts the operand
//   out_data_o   extended operand
//   out_err_o    operand malformed (reserved mode or HIGH overwritten)
//   pending_o    an upper half is held, waiting for its LOW
module imm_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_imm_i,
    input  logic [1:0]       in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_err_o,
    output logic             pending_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_LOW = 2'd1,
        S_HOLD     = 2'd2
    } state_e;

    localparam logic [1:0] M_SEXT = 2'b00;
    localparam logic [1:0] M_ZEXT = 2'b01;
    localparam logic [1:0] M_HIGH = 2'b10;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             pend_q, pend_d;
    logic [15:0]      hi_q, hi_d;
    logic             bad_q, bad_d;   // a HIGH was overwritten before its LOW

    logic             accept, deliver;
    logic [WIDTH-1:0] sext16, zext16, pair_ext;
    logic [31:0]      pair;

    // New-operand decode shared by IDLE and HOLD-with-deliver
    state_e           nw_state;
    logic [WIDTH-1:0] nw_data;
    logic             nw_err;

    // In HOLD the slot frees up exactly when the consumer takes it, so the
    // ready path is combinational to allow one operand per cycle.
    assign in_ready_o = (state_q != S_HOLD) || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign deliver    = valid_q && out_ready_i;

    always_comb begin
        sext16 = {{(WIDTH-16){in_imm_i[15]}}, in_imm_i};
        zext16 = {{(WIDTH-16){1'b0}}, in_imm_i};
        pair   = {hi_q, in_imm_i};
        // Written as fill-then-overlay so WIDTH == 32 needs no zero-width
        // replication.
        pair_ext       = {WIDTH{pair[31]}};
        pair_ext[31:0] = pair;
    end

    always_comb begin
        nw_state = S_HOLD;
        nw_data  = data_q;
        nw_err   = 1'b0;
        unique case (in_mode_i)
            M_SEXT:  nw_data = sext16;
            M_ZEXT:  nw_data = zext16;
            M_HIGH:  nw_state = S_WAIT_LOW;
            default: begin
                nw_data = '0;
                nw_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        hi_d    = hi_q;
        bad_d   = bad_q;

        if (flush_i) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            hi_d    = '0;
            bad_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HOLD: begin
                    if (state_q == S_HOLD && deliver) state_d = S_IDLE;
                    if (accept) begin
                        state_d = nw_state;
                        if (nw_state == S_WAIT_LOW) begin
                            hi_d  = in_imm_i;
                            bad_d = 1'b0;
                        end else begin
                            data_d = nw_data;
                            err_d  = nw_err;
                        end
                    end
                end
                S_WAIT_LOW: begin
                    if (accept) begin
                        unique case (in_mode_i)
                            M_SEXT, M_ZEXT: begin
                                data_d  = pair_ext;
                                err_d   = bad_q;
                                bad_d   = 1'b0;
                                state_d = S_HOLD;
                            end
                            M_HIGH: begin
                                hi_d  = in_imm_i;
                                bad_d = 1'b1;
                            end
                            default: begin
                                data_d  = '0;
                                err_d   = 1'b1;
                                hi_d    = '0;
                                bad_d   = 1'b0;
                                state_d = S_HOLD;
                            end
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Status outputs are registered copies of the next-state decode
        valid_d = (state_d == S_HOLD);
        pend_d  = (state_d == S_WAIT_LOW);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            hi_q    <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            bad_q   <= bad_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_err_o   = err_q;
    assign pending_o   = pend_q;

endmodule

// File: tb/tb_imm_sequencer.sv
module tb_imm_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             pending;

    int checks = 0;
    int errors = 0;

    imm_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_imm_i   (in_imm),
        .in_mode_i  (in_mode),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_err_o  (out_err),
        .pending_o  (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm);
        in_valid = v;
        in_mode  = m;
        in_imm   = imm;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || pending !== 1'b0 ||
            out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b err=%b pend=%b data=%h rdy=%b, want 0 0 0 00000000 1",
                     out_valid, out_err, pending, out_data, in_ready);
        end
    endtask

    task automatic test_sext();
        drive(1'b1, 2'b00, 16'hFFFF);
        tick();
        drive(1'b0, 2'b00, 16'h0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_err !== 1'b0) begin
            errors++;
            $display("FAIL sext: valid=%b data=%h err=%b, want 1 ffffffff 0", out_valid, out_data, out_err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sext_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 16'h8000);
        tick();
        drive(1'b1, 2'b00, 16'h7777);  // offered but must stall
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h0000_8000 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL zext_hold[%0d]: valid=%b data=%h rdy=%b, want 1 00008000 0",
                         i, out_valid, out_data, in_ready);
            end
            tick();
        end
        drive(1'b0, 2'b00, 16'h0);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zext_release_rdy: rdy=%b, want 1", in_ready);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zext_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_pair();
        drive(1'b1, 2'b10, 16'h1234);
        tick();
        checks++;
        if (pending !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pair_pending: pend=%b valid=%b, want 1 0", pending, out_valid);
        end
        drive(1'b1, 2'b00, 16'h8001);
        tick();
        drive(1'b0, 2'b00, 16'h0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_8001 || out_err !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL pair: valid=%b data=%h err=%b pend=%b, want 1 12348001 0 0",
                     out_valid, out_data, out_err, pending);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overwrite();
        drive(1'b1, 2'b10, 16'hAAAA); tick();
        drive(1'b1, 2'b10, 16'h0001); tick();
        drive(1'b1, 2'b01, 16'h0100); tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0001_0100 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL overwrite: valid=%b data=%h err=%b, want 1 00010100 1", out_valid, out_data, out_err);
        end
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 16'd14); tick();
        drive(1'b0, 2'b00, 16'h0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd14 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL after_overwrite: valid=%b data=%h err=%b, want 1 0000000e 0", out_valid, out_data, out_err);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  m   [3];
        logic [15:0] imm [3];
        logic [31:0] exp [3];
        m[0] = 2'b00; imm[0] = 16'd256;  exp[0] = 32'd256;
        m[1] = 2'b01; imm[1] = 16'd14;   exp[1] = 32'd14;
        m[2] = 2'b00; imm[2] = 16'hFFFF; exp[2] = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, m[i], imm[i]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d]: valid=%b data=%h err=%b, want 1 %h 0", i, out_valid, out_data, out_err, exp[i]);
            end
        end
        drive(1'b0, 2'b00, 16'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reserved();
        drive(1'b1, 2'b11, 16'h1357); tick();
        drive(1'b0, 2'b00, 16'h0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL reserved: valid=%b data=%h err=%b, want 1 00000000 1", out_valid, out_data, out_err);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_flush_reset();
        drive(1'b1, 2'b10, 16'h5555); tick();
        flush = 1'b1;
        drive(1'b1, 2'b00, 16'h0001); tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 16'h0);
        tick();
        checks++;
        if (pending !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL flush: pend=%b valid=%b err=%b, want 0 0 0", pending, out_valid, out_err);
        end
        drive(1'b1, 2'b10, 16'h5555); tick();
        drive(1'b0, 2'b00, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pending !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: pend=%b valid=%b rdy=%b, want 0 0 1", pending, out_valid, in_ready);
        end
        tick();
        rst_n = 1'b1;
        // A lone LOW after reset must be a plain extension: the old hi is gone
        drive(1'b1, 2'b01, 16'h0042); tick();
        drive(1'b0, 2'b00, 16'h0);
        checks++;
        if (out_data !== 32'h0000_0042 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_low: data=%h err=%b, want 00000042 0", out_data, out_err);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    // Transaction-level reference: an output slot plus an optional held
    // upper half, updated from the handshake rules each cycle.
    task automatic test_random();
        bit          m_full = 0, m_hi_vld = 0, m_bad = 0, m_err = 0;
        logic [15:0] m_hi = 0;
        logic [31:0] m_data = 0;
        bit          rdy, v, f, o;
        logic [1:0]  md;
        logic [15:0] im;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(99) < 65);
            o  = ($urandom_range(99) < 70);
            f  = ($urandom_range(99) < 4);
            md = ($urandom_range(99) < 10) ? 2'b11 : 2'($urandom_range(2));
            im = 16'($urandom);
            drive(v, md, im);
            out_ready = o;
            flush     = f;
            #1;
            rdy = !m_full || o;
            checks++;
            if (in_ready !== rdy) begin
                errors++;
                $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, rdy);
            end
            if (f) begin
                m_full = 0; m_hi_vld = 0; m_bad = 0; m_err = 0; m_hi = 0;
            end else begin
                if (m_full && o) m_full = 0;
                if (v && rdy) begin
                    if (m_hi_vld) begin
                        if (md == 2'b10) begin
                            m_hi = im; m_bad = 1;
                        end else begin
                            m_data = (md == 2'b11) ? 32'h0 : 32'(int'($signed({m_hi, im})));
                            m_err  = (md == 2'b11) ? 1'b1 : m_bad;
                            m_full = 1; m_hi_vld = 0; m_bad = 0;
                            if (md == 2'b11) m_hi = 0;
                        end
                    end else begin
                        case (md)
                            2'b00: begin m_data = 32'(int'($signed(im))); m_err = 0; m_full = 1; end
                            2'b01: begin m_data = {16'h0, im}; m_err = 0; m_full = 1; end
                            2'b10: begin m_hi = im; m_hi_vld = 1; m_bad = 0; end
                            default: begin m_data = 32'h0; m_err = 1; m_full = 1; end
                        endcase
                    end
                end
            end
            tick();
            checks++;
            if (out_valid !== m_full || pending !== m_hi_vld ||
                (m_full && (out_data !== m_data || out_err !== m_err))) begin
                errors++;
                $display("FAIL rnd_out c%0d: valid=%b pend=%b data=%h err=%b, want %b %b %h %b",
                         c, out_valid, pending, out_data, out_err, m_full, m_hi_vld, m_data, m_err);
            end
        end
        flush = 1'b0;
        drive(1'b0, 2'b00, 16'h0);
    endtask

    initial begin
        test_reset();
        test_sext();
        test_backpressure();
        test_pair();
        test_overwrite();
        test_back_to_back();
        test_reserved();
        test_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
